// File: rtl/dram_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the DRAM arbiter.
package dram_arb_pkg;

   localparam int unsigned DEF_NUM_REQ = 2;
   localparam int unsigned DEF_ADDR_W  = 2;
   localparam int unsigned DEF_DATA_W  = 72;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR     = 2'd1,
      RD     = 2'd2,
      RD_RSP = 2'd3
   } arbState_e;

   // Width of an index into n requesters, never below one bit.
   function automatic int unsigned idxWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dram_arb_rr_arb.sv
// Round-robin grant selection: first valid requester at or above ptr wins,
// otherwise wrap around to the lowest valid requester.
module rr_arb
   import dram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   localparam int unsigned PTR_W  = idxWidth(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_c
);

   logic [NUM_REQ-1:0] highMask;
   logic [NUM_REQ-1:0] maskedReq;

   // Isolate the lowest set bit of the masked (or, failing that, raw) request vector.
   always_comb begin
      highMask  = {NUM_REQ{1'b1}} << ptr;
      maskedReq = req & highMask;
      if (|maskedReq) begin
         grant_c = maskedReq & (~maskedReq + NUM_REQ'(1));
      end else begin
         grant_c = req & (~req + NUM_REQ'(1));
      end
   end

endmodule

// File: rtl/dram_arb.sv
// Arbitrates NUM_REQ requesters onto a single-port DRAM with one-cycle
// writes and a registered read response.
module dram_arb
   import dram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         dram_address,
   output logic [DATA_W-1:0]         dram_dataIN,
   output logic                      dram_Write_ReadCOMP,
   input  logic [DATA_W-1:0]         dram_dataOUT
);

   localparam int unsigned ID_W = idxWidth(NUM_REQ);

   arbState_e           state;
   logic [ID_W-1:0]     rrPtr;
   logic [ID_W-1:0]     reqId;
   logic [ID_W-1:0]     grantIdx;
   logic [NUM_REQ-1:0]  grant;
   logic                accept;
   logic [ADDR_W-1:0]   selAddr;
   logic [DATA_W-1:0]   selData;
   logic                selWe;

   rr_arb #(.NUM_REQ(NUM_REQ)) uRrArb (
      .req     (req_valid),
      .ptr     (rrPtr),
      .grant_c (grant)
   );

   // Ready is only offered in IDLE and is gated by reset so it drops immediately.
   always_comb begin
      req_ready = (state == IDLE && rst_n) ? grant : '0;
      accept    = |req_ready;
   end

   // Mux out the winning requester's fields.
   always_comb begin
      grantIdx = '0;
      selAddr  = '0;
      selData  = '0;
      selWe    = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant[i]) begin
            grantIdx = ID_W'(i);
            selAddr  = req_addr[i*ADDR_W +: ADDR_W];
            selData  = req_wdata[i*DATA_W +: DATA_W];
            selWe    = req_we[i];
         end
      end
   end

   // Arbiter FSM with registered DRAM drive and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         rrPtr               <= '0;
         reqId               <= '0;
         busy                <= 1'b0;
         rsp_valid           <= '0;
         rsp_rdata           <= '0;
         dram_address        <= '0;
         dram_dataIN         <= '0;
         dram_Write_ReadCOMP <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  reqId               <= grantIdx;
                  dram_address        <= selAddr;
                  dram_dataIN         <= selData;
                  dram_Write_ReadCOMP <= selWe;
                  busy                <= 1'b1;
                  rrPtr               <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0
                                                                          : grantIdx + ID_W'(1);
                  state               <= selWe ? WR : RD;
               end
            end
            WR: begin
               dram_Write_ReadCOMP <= 1'b0;
               busy                <= 1'b0;
               state               <= IDLE;
            end
            RD: begin
               state <= RD_RSP;
            end
            RD_RSP: begin
               rsp_rdata        <= dram_dataOUT;
               rsp_valid[reqId] <= 1'b1;
               busy             <= 1'b0;
               state            <= IDLE;
            end
            default: begin
               dram_Write_ReadCOMP <= 1'b0;
               busy                <= 1'b0;
               state               <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb with a small behavioral DRAM model.
module tb_dram_arb;

   logic         clk;
   logic         rst_n;
   logic [1:0]   req_valid;
   logic [1:0]   req_we;
   logic [3:0]   req_addr;
   logic [143:0] req_wdata;
   logic [1:0]   req_ready;
   logic [1:0]   rsp_valid;
   logic [71:0]  rsp_rdata;
   logic         busy;
   logic [1:0]   dram_address;
   logic [71:0]  dram_dataIN;
   logic         dram_Write_ReadCOMP;
   logic [71:0]  dram_dataOUT;

   logic [71:0]  mem [4];
   int           nCompared;
   int           nMismatched;

   dram_arb dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .req_valid           (req_valid),
      .req_we              (req_we),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .req_ready           (req_ready),
      .rsp_valid           (rsp_valid),
      .rsp_rdata           (rsp_rdata),
      .busy                (busy),
      .dram_address        (dram_address),
      .dram_dataIN         (dram_dataIN),
      .dram_Write_ReadCOMP (dram_Write_ReadCOMP),
      .dram_dataOUT        (dram_dataOUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port DRAM: write when Write_ReadCOMP high, read data registered.
   always @(posedge clk) begin
      if (dram_Write_ReadCOMP) mem[dram_address] <= dram_dataIN;
      dram_dataOUT <= mem[dram_address];
   end

   task automatic checkVal(input string tag, input logic [71:0] got, input logic [71:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleReq();
      req_valid = 2'b00;
      req_we    = 2'b00;
   endtask

   // Requester 1 write used to preload memory through the DUT.
   task automatic write1(input logic [1:0] addr, input logic [71:0] data);
      req_valid        = 2'b10;
      req_we           = 2'b10;
      req_addr[3:2]    = addr;
      req_wdata[143:72] = data;
      #1 checkVal("wr1_ready", 72'(req_ready), 72'(2'b10));
      step();
      idleReq();
      checkVal("wr1_wrc", 72'(dram_Write_ReadCOMP), 72'(1'b1));
      checkVal("wr1_addr", 72'(dram_address), 72'(addr));
      step();
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst_n       = 1'b0;
      req_valid   = 2'b11;
      req_we      = 2'b00;
      req_addr    = '0;
      req_wdata   = '0;

      // Reset state: all outputs zero, no ready even with requests pending.
      #3;
      checkVal("rst_ready", 72'(req_ready), 72'(2'b00));
      checkVal("rst_busy", 72'(busy), 72'(1'b0));
      checkVal("rst_wrc", 72'(dram_Write_ReadCOMP), 72'(1'b0));
      checkVal("rst_rdata", rsp_rdata, 72'(0));
      idleReq();
      #20 rst_n = 1'b1;
      step();

      // req0 write addr=2 data=12: one write cycle, busy for one cycle.
      req_valid      = 2'b01;
      req_we         = 2'b01;
      req_addr[1:0]  = 2'd2;
      req_wdata[71:0] = 72'd12;
      #1 checkVal("w0_ready", 72'(req_ready), 72'(2'b01));
      step();
      idleReq();
      checkVal("w0_wrc", 72'(dram_Write_ReadCOMP), 72'(1'b1));
      checkVal("w0_addr", 72'(dram_address), 72'(2'd2));
      checkVal("w0_data", dram_dataIN, 72'd12);
      checkVal("w0_busy", 72'(busy), 72'(1'b1));
      checkVal("w0_ready_wr", 72'(req_ready), 72'(2'b00));
      step();
      checkVal("w0_wrc_off", 72'(dram_Write_ReadCOMP), 72'(1'b0));
      checkVal("w0_busy_off", 72'(busy), 72'(1'b0));
      checkVal("w0_addr_hold", 72'(dram_address), 72'(2'd2));
      checkVal("w0_mem", mem[2], 72'd12);

      // req1 write addr=3 data=23, then read it back.
      write1(2'd3, 72'd23);
      req_valid     = 2'b10;
      req_we        = 2'b00;
      req_addr[3:2] = 2'd3;
      #1 checkVal("r1_ready", 72'(req_ready), 72'(2'b10));
      step();
      idleReq();
      checkVal("r1_wrc", 72'(dram_Write_ReadCOMP), 72'(1'b0));
      checkVal("r1_rsp_e0", 72'(rsp_valid), 72'(2'b00));
      step();
      checkVal("r1_rsp_e1", 72'(rsp_valid), 72'(2'b00));
      checkVal("r1_busy", 72'(busy), 72'(1'b1));
      step();
      checkVal("r1_rsp", 72'(rsp_valid), 72'(2'b10));
      checkVal("r1_rdata", rsp_rdata, 72'd23);
      checkVal("r1_busy_off", 72'(busy), 72'(1'b0));
      step();
      checkVal("r1_rsp_off", 72'(rsp_valid), 72'(2'b00));
      checkVal("r1_rdata_hold", rsp_rdata, 72'd23);

      // Preload addr0=5, addr1=7 via requester 1 so requester 0 has priority next.
      write1(2'd0, 72'd5);
      write1(2'd1, 72'd7);

      // Both valid continuously: grants alternate, back-to-back from the response cycle.
      req_valid     = 2'b11;
      req_we        = 2'b00;
      req_addr      = {2'd1, 2'd0};
      #1;
      for (int k = 0; k < 4; k++) begin
         logic [1:0]  expGrant;
         logic [71:0] expData;
         expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
         expData  = (k % 2 == 0) ? 72'd5 : 72'd7;
         checkVal($sformatf("rr_ready%0d", k), 72'(req_ready), 72'(expGrant));
         step();
         step();
         step();
         checkVal($sformatf("rr_rsp%0d", k), 72'(rsp_valid), 72'(expGrant));
         checkVal($sformatf("rr_rdata%0d", k), rsp_rdata, expData);
      end
      idleReq();
      step();

      // Reset asserted during RD: outputs clear at once, response never appears.
      req_valid     = 2'b01;
      req_we        = 2'b00;
      req_addr[1:0] = 2'd1;
      #1 checkVal("rr_ready_rst", 72'(req_ready), 72'(2'b01));
      step();
      idleReq();
      checkVal("rd_busy", 72'(busy), 72'(1'b1));
      rst_n = 1'b0;
      #1;
      checkVal("mrst_busy", 72'(busy), 72'(1'b0));
      checkVal("mrst_addr", 72'(dram_address), 72'(2'd0));
      checkVal("mrst_data", dram_dataIN, 72'(0));
      checkVal("mrst_rdata", rsp_rdata, 72'(0));
      checkVal("mrst_rsp", 72'(rsp_valid), 72'(2'b00));
      checkVal("mrst_wrc", 72'(dram_Write_ReadCOMP), 72'(1'b0));
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checkVal($sformatf("mrst_norsp%0d", k), 72'(rsp_valid), 72'(2'b00));
      end

      // After reset requester 0 wins the first contended grant.
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {2'd1, 2'd0};
      #1 checkVal("post_rst_ready", 72'(req_ready), 72'(2'b01));
      step();
      idleReq();
      step();
      step();
      checkVal("post_rst_rsp", 72'(rsp_valid), 72'(2'b01));
      checkVal("post_rst_rdata", rsp_rdata, 72'd5);
      step();

      // Full-width data round trip on addr=1.
      req_valid       = 2'b01;
      req_we          = 2'b01;
      req_addr[1:0]   = 2'd1;
      req_wdata[71:0] = {72{1'b1}};
      #1 checkVal("fw_wready", 72'(req_ready), 72'(2'b01));
      step();
      idleReq();
      checkVal("fw_dataIN", dram_dataIN, {72{1'b1}});
      step();
      req_valid = 2'b01;
      req_we    = 2'b00;
      #1 checkVal("fw_rready", 72'(req_ready), 72'(2'b01));
      step();
      idleReq();
      step();
      step();
      checkVal("fw_rsp", 72'(rsp_valid), 72'(2'b01));
      checkVal("fw_rdata", rsp_rdata, {72{1'b1}});
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/dram_arb.md
DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 SHALL have parameter: NUM_REQ, 2, number of requesters sharing the DRAM.
REQ-002 SHALL have parameter: ADDR_W, 2, DRAM address width (4 words).
REQ-003 SHALL have parameter: DATA_W, 72, DRAM word width.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port: req_we  input  NUM_REQ  per-requester 1=write, 0=read.
REQ-008 SHALL have port: req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port: req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
REQ-010 SHALL have port: req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-011 SHALL have port: rsp_valid  output  NUM_REQ  one-hot read-data strobe, one cycle.
REQ-012 SHALL have port: rsp_rdata  output  DATA_W  read data, valid when any rsp_valid bit high.
REQ-013 SHALL have port: busy  output  1  high whenever FSM not IDLE.
REQ-014 SHALL have port: dram_address  output  ADDR_W  to DRAM address.
REQ-015 SHALL have port: dram_dataIN  output  DATA_W  to DRAM dataIN.
REQ-016 SHALL have port: dram_Write_ReadCOMP  output  1  to DRAM Write_ReadCOMP; 1=write on next edge, 0=read.
REQ-017 SHALL have port: dram_dataOUT  input  DATA_W  from DRAM dataOUT, updated at the edge after a read address is presented.

Function
REQ-018 SHALL implement FSM states IDLE, WR, RD, RD_RSP.
REQ-019 SHALL, in IDLE with rst_n high, assert req_ready for exactly the winner among valid requesters, combinationally; no bit when none valid.
REQ-020 SHALL accept a request (valid&ready at edge) by latching addr, wdata, we, requester id; next state WR if we=1 else RD.
REQ-021 SHALL arbitrate round-robin: when both valid, grant the requester not granted last; single valid requester always wins.
REQ-022 SHALL, in WR, drive dram_address/dram_dataIN from latched values and dram_Write_ReadCOMP=1 for exactly one cycle, then return to IDLE (write accept-to-accept 2 cycles).
REQ-023 SHALL, in RD, drive latched address with dram_Write_ReadCOMP=0, then go to RD_RSP.
REQ-024 SHALL, at the edge ending RD_RSP, capture dram_dataOUT into rsp_rdata and set rsp_valid[id] for exactly one cycle; FSM returns to IDLE at the same edge.
REQ-025 SHALL give read latency of 3 edges from accept edge to rsp_valid high; a new request MAY be accepted in the cycle rsp_valid is high.
REQ-026 SHALL hold dram_Write_ReadCOMP=0 in every state except WR; dram_address and rsp_rdata hold last value otherwise.
REQ-027 SHALL not support response backpressure; requester must sample rsp_valid/rsp_rdata in the strobe cycle.
REQ-028 SHALL ignore req_valid changes outside IDLE; a dropped unaccepted request has no effect.

Reset
REQ-029 SHALL, on rst_n low, immediately force FSM=IDLE, req_ready=0, rsp_valid=0, busy=0, rsp_rdata=0, dram_address=0, dram_dataIN=0, dram_Write_ReadCOMP=0.
REQ-030 SHALL set round-robin pointer so requester 0 wins the first contended grant after reset.
REQ-031 SHALL discard any in-flight operation on reset mid-operation; no rsp_valid is produced for it.

Structure
REQ-032 SHALL place state encoding and default ADDR_W/DATA_W/NUM_REQ constants in package dram_arb_pkg.
REQ-033 SHALL implement grant selection in sub-module rr_arb (req vector, pointer in, one-hot grant out).

Verification
REQ-034 SHALL cover: req0 write addr=2 data=12 -> dram_Write_ReadCOMP=1 one cycle with address=2, dataIN=12; busy 1 cycle.
REQ-035 SHALL cover: req1 write addr=3 data=23, then read addr=3 -> rsp_valid=2'b10, rsp_rdata=23, 3 edges after read accept.
REQ-036 SHALL cover: both valid continuously (reads addr 0/1 preloaded 5/7) -> grants alternate 0,1,0,1; rsp_rdata 5,7,5,7.
REQ-037 SHALL cover: rst_n low during RD -> outputs zero immediately, no rsp_valid afterwards, next accept from IDLE.
REQ-038 SHALL cover: write addr=1 data=72'hFF..FF then read addr=1 -> full 72-bit value returned unchanged.
